// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//
// Commit-trace capture buffer. Records retired instructions (PC, optional
// register writeback, timestamp) into a circular buffer that a consumer drains
// through a valid/ready handshake. Filtering keeps only commits that write a
// watched register; the full-buffer policy either drops new entries or
// discards the oldest one, and every lost entry is counted.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en, clear           capture enable, synchronous flush
//   commit_valid/_pc    retiring instruction and its PC
//   wb_en/_addr/_data   register writeback of the retiring instruction
//   out_valid/_ready    head-entry handshake (pop = out_valid && out_ready)
//   out_pc/_has_wb/_addr/_data/_ts  head entry fields (combinational read)
//   count               occupied entries, 0..DEPTH
//   overflow            sticky: an entry was dropped or overwritten
//   dropped             lost-entry counter, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module cpu_trace_buffer #(
    parameter int          PC_W       = 32,
    parameter int          DATA_W     = 32,
    parameter int          REG_AW     = 5,
    parameter int          DEPTH      = 16,
    parameter int          TS_W       = 16,
    parameter logic [31:0] WATCH_MASK = 32'h0000_007C,
    parameter int          FILTER     = 0,
    parameter int          OVERWRITE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     commit_valid,
    input  logic [PC_W-1:0]          commit_pc,
    input  logic                     wb_en,
    input  logic [REG_AW-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_has_wb,
    output logic [REG_AW-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
    localparam logic [15:0]     DROP_ONE = 16'd1;
    localparam logic [15:0]     DROP_MAX = 16'hFFFF;

    // Watch-mask lookup; register numbers beyond bit 31 of the mask never hit.
    function automatic logic watch_hit(input logic [REG_AW-1:0] addr);
        logic [REG_AW+4:0] wide;
        wide = {5'b00000, addr};
        if (wide[REG_AW+4:5] != '0) begin
            return 1'b0;
        end else begin
            return WATCH_MASK[wide[4:0]];
        end
    endfunction

    logic [PC_W-1:0]   mem_pc_r   [DEPTH];
    logic              mem_wb_r   [DEPTH];
    logic [REG_AW-1:0] mem_addr_r [DEPTH];
    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [TS_W-1:0]   mem_ts_r   [DEPTH];

    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic [TS_W-1:0] ts_r;
    logic            overflow_r;
    logic [15:0]     dropped_r;

    logic            hit_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            write_s;
    logic            lose_s;
    logic            adv_s;
    logic [CW-1:0]   count_nxt_s;

    // Capture/consume decisions and the resulting occupancy for this cycle.
    always_comb begin
        hit_s       = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        full_s      = 1'b0;
        write_s     = 1'b0;
        lose_s      = 1'b0;
        adv_s       = 1'b0;
        count_nxt_s = count_r;

        hit_s  = wb_en && watch_hit(wb_addr);
        push_s = en && commit_valid && ((FILTER == 0) || hit_s);
        pop_s  = (count_r != '0) && out_ready;
        full_s = (count_r == CNT_FULL);

        // A push into a full buffer without a pop loses one entry: either the
        // new one (no write) or the oldest one (write plus extra read advance).
        lose_s = push_s && full_s && !pop_s;
        if (lose_s) begin
            write_s = (OVERWRITE != 0);
            adv_s   = (OVERWRITE != 0);
        end else begin
            write_s = push_s;
            adv_s   = pop_s;
        end

        case ({write_s, adv_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and loss accounting; clear flushes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            dropped_r  <= 16'd0;
        end else if (clear) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            dropped_r  <= 16'd0;
        end else begin
            if (write_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (adv_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            if (lose_s) begin
                overflow_r <= 1'b1;
                if (dropped_r != DROP_MAX) begin
                    dropped_r <= dropped_r + DROP_ONE;
                end
            end
        end
    end

    // Free-running timestamp; only reset stops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_ONE;
        end
    end

    // Entry storage; contents are not reset, occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!clear && write_s) begin
            mem_pc_r[wptr_r]   <= commit_pc;
            mem_wb_r[wptr_r]   <= wb_en;
            mem_addr_r[wptr_r] <= wb_en ? wb_addr : '0;
            mem_data_r[wptr_r] <= wb_en ? wb_data : '0;
            mem_ts_r[wptr_r]   <= ts_r;
        end
    end

    assign out_valid  = (count_r != '0);
    assign out_pc     = mem_pc_r[rptr_r];
    assign out_has_wb = mem_wb_r[rptr_r];
    assign out_addr   = mem_addr_r[rptr_r];
    assign out_data   = mem_data_r[rptr_r];
    assign out_ts     = mem_ts_r[rptr_r];
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign dropped    = dropped_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_buffer
//
// Four buffer configurations share one stimulus stream:
//   0: DEPTH=16, drop-new          1: DEPTH=4, drop-new
//   2: DEPTH=4, overwrite, TS_W=4  3: DEPTH=8, filtered on watched registers
// A queue-based model per configuration predicts every output each cycle;
// directed scenarios add literal expectations on top of it.
// -----------------------------------------------------------------------------
module tb_cpu_trace_buffer;

    localparam int NI = 4;

    function automatic int dep_of(input int g);
        case (g)
            0:       return 16;
            1:       return 4;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int tsw_of(input int g);
        return (g == 2) ? 4 : 16;
    endfunction

    function automatic int fil_of(input int g);
        return (g == 3) ? 1 : 0;
    endfunction

    function automatic int ovw_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst;
    logic        en;
    logic        clear;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_ready;

    logic        o_valid [NI];
    logic [31:0] o_pc    [NI];
    logic        o_wb    [NI];
    logic [4:0]  o_addr  [NI];
    logic [31:0] o_data  [NI];
    logic [15:0] o_ts    [NI];
    logic [4:0]  o_cnt   [NI];
    logic        o_ov    [NI];
    logic [15:0] o_drop  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = dep_of(g);
        localparam int TW = tsw_of(g);
        logic [$clog2(D):0] cnt;
        logic [TW-1:0]      ts;

        cpu_trace_buffer #(
            .PC_W(32), .DATA_W(32), .REG_AW(5), .DEPTH(D), .TS_W(TW),
            .WATCH_MASK(32'h0000_007C), .FILTER(fil_of(g)), .OVERWRITE(ovw_of(g))
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .clear(clear),
            .commit_valid(commit_valid), .commit_pc(commit_pc),
            .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
            .out_valid(o_valid[g]), .out_ready(out_ready),
            .out_pc(o_pc[g]), .out_has_wb(o_wb[g]), .out_addr(o_addr[g]),
            .out_data(o_data[g]), .out_ts(ts), .count(cnt),
            .overflow(o_ov[g]), .dropped(o_drop[g])
        );

        assign o_cnt[g] = 5'(cnt);
        assign o_ts[g]  = 16'(ts);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        wb;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] ts;
    } ent_t;

    ent_t mq [NI][$];
    int   m_ov [NI];
    int   m_dr [NI];
    int   m_ts [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_ov[i] = 0;
            m_dr[i] = 0;
            m_ts[i] = 0;
        end
    endtask

    // One clock edge of the reference, using the inputs that were held at it.
    task automatic model_step();
        logic [31:0] mask;
        logic        hit, push, pop;
        ent_t        e;
        mask = 32'h0000_007C;
        for (int i = 0; i < NI; i++) begin
            hit  = wb_en && mask[wb_addr];
            push = en && commit_valid && (fil_of(i) == 0 || hit);
            pop  = out_ready && (mq[i].size() > 0);
            e.pc   = commit_pc;
            e.wb   = wb_en;
            e.addr = wb_en ? wb_addr : 5'd0;
            e.data = wb_en ? wb_data : 32'd0;
            e.ts   = 16'(m_ts[i]);
            if (clear) begin
                mq[i].delete();
                m_ov[i] = 0;
                m_dr[i] = 0;
            end else begin
                if (pop) void'(mq[i].pop_front());
                if (push) begin
                    if (mq[i].size() < dep_of(i)) begin
                        mq[i].push_back(e);
                    end else begin
                        m_ov[i] = 1;
                        if (m_dr[i] < 65535) m_dr[i]++;
                        if (ovw_of(i) != 0) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(e);
                        end
                    end
                end
            end
            m_ts[i] = (m_ts[i] + 1) % (1 << tsw_of(i));
        end
    endtask

    initial model_reset();

    ent_t cmp_e;

    // Compare process: advance the model by the edge just past, then check all outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_step();
                for (int i = 0; i < NI; i++) begin
                    chk("count", i, 64'(o_cnt[i]), 64'(mq[i].size()));
                    chk("out_valid", i, 64'(o_valid[i]), 64'(mq[i].size() != 0));
                    chk("overflow", i, 64'(o_ov[i]), 64'(m_ov[i]));
                    chk("dropped", i, 64'(o_drop[i]), 64'(m_dr[i]));
                    if (mq[i].size() != 0) begin
                        cmp_e = mq[i][0];
                        chk("out_pc", i, 64'(o_pc[i]), 64'(cmp_e.pc));
                        chk("out_has_wb", i, 64'(o_wb[i]), 64'(cmp_e.wb));
                        chk("out_addr", i, 64'(o_addr[i]), 64'(cmp_e.addr));
                        chk("out_data", i, 64'(o_data[i]), 64'(cmp_e.data));
                        chk("out_ts", i, 64'(o_ts[i]), 64'(cmp_e.ts));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge: drive one cycle of inputs, return at the next falling edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rdy, input logic clr);
        #1;
        commit_valid = v;
        commit_pc    = pc;
        wb_en        = we;
        wb_addr      = wa;
        wb_data      = wd;
        out_ready    = rdy;
        clear        = clr;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic flush();
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    endtask

    logic [15:0] ts0, prev_ts;
    logic        seen_wrap;

    initial begin
        rst = 1'b0; en = 1'b1; clear = 1'b0; commit_valid = 1'b0; commit_pc = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("reset_valid", 0, 64'(o_valid[0]), 64'd0);
        chk("reset_overflow", 0, 64'(o_ov[0]), 64'd0);
        chk("reset_dropped", 0, 64'(o_drop[0]), 64'd0);

        // Five commits, then drain in order with consecutive timestamps.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'(4 * k), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("s1_count", 0, 64'(o_cnt[0]), 64'd5);
        chk("s1_head_pc", 0, 64'(o_pc[0]), 64'd0);
        ts0 = o_ts[0];
        for (int k = 1; k < 5; k++) begin
            idle(1'b1);
            chk("s1_read_pc", 0, 64'(o_pc[0]), 64'(4 * k));
            chk("s1_read_ts", 0, 64'(o_ts[0]), 64'(16'(ts0 + 16'(k))));
        end
        idle(1'b1);
        chk("s1_empty_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("s1_empty_valid", 0, 64'(o_valid[0]), 64'd0);

        // Filtered capture: only r3 and r6 are watched among r1, r3, r7, r6.
        flush();
        cyc(1'b1, 32'd100, 1'b1, 5'd1, 32'd11, 1'b0, 1'b0);
        cyc(1'b1, 32'd104, 1'b1, 5'd3, 32'd7,  1'b0, 1'b0);
        cyc(1'b1, 32'd108, 1'b1, 5'd7, 32'd13, 1'b0, 1'b0);
        cyc(1'b1, 32'd112, 1'b1, 5'd6, 32'd9,  1'b0, 1'b0);
        chk("s2_count", 3, 64'(o_cnt[3]), 64'd2);
        chk("s2_addr0", 3, 64'(o_addr[3]), 64'd3);
        chk("s2_data0", 3, 64'(o_data[3]), 64'd7);
        chk("s2_overflow", 3, 64'(o_ov[3]), 64'd0);
        idle(1'b1);
        chk("s2_addr1", 3, 64'(o_addr[3]), 64'd6);
        chk("s2_data1", 3, 64'(o_data[3]), 64'd9);

        // Six commits into DEPTH=4: drop-new keeps 0..12, overwrite keeps 8..20.
        flush();
        for (int k = 0; k < 6; k++) cyc(1'b1, 32'(4 * k), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("s3_count", 1, 64'(o_cnt[1]), 64'd4);
        chk("s3_overflow", 1, 64'(o_ov[1]), 64'd1);
        chk("s3_dropped", 1, 64'(o_drop[1]), 64'd2);
        chk("s3_count", 2, 64'(o_cnt[2]), 64'd4);
        chk("s3_dropped", 2, 64'(o_drop[2]), 64'd2);
        for (int k = 0; k < 4; k++) begin
            chk("s3_order", 1, 64'(o_pc[1]), 64'(4 * k));
            chk("s3_order", 2, 64'(o_pc[2]), 64'(8 + 4 * k));
            idle(1'b1);
        end

        // Full buffer with push and pop together, then clear overriding a push.
        flush();
        for (int k = 0; k < 6; k++) cyc(1'b1, 32'(4 * k), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'(200 + 4 * k), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
            chk("s4_count", 1, 64'(o_cnt[1]), 64'd4);
            chk("s4_dropped", 1, 64'(o_drop[1]), 64'd2);
            chk("s4_overflow", 1, 64'(o_ov[1]), 64'd1);
        end
        cyc(1'b1, 32'd400, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        chk("s4_clr_count", 1, 64'(o_cnt[1]), 64'd0);
        chk("s4_clr_overflow", 1, 64'(o_ov[1]), 64'd0);
        chk("s4_clr_dropped", 1, 64'(o_drop[1]), 64'd0);

        // Asynchronous reset in the middle of a readout.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'(500 + 4 * k), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("s5_async_valid", i, 64'(o_valid[i]), 64'd0);
            chk("s5_async_count", i, 64'(o_cnt[i]), 64'd0);
        end
        commit_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("s5_after_count", 0, 64'(o_cnt[0]), 64'd0);

        // Timestamp wrap on the 4-bit instance.
        seen_wrap = 1'b0;
        prev_ts = 16'd0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 32'(4 * k), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
            if (k > 0) begin
                chk("s6_ts_step", 2, 64'(o_ts[2]), 64'((prev_ts + 16'd1) % 16'd16));
                if (prev_ts == 16'd15 && o_ts[2] == 16'd0) seen_wrap = 1'b1;
            end
            prev_ts = o_ts[2];
        end
        chk("s6_ts_wrap_seen", 2, 64'(seen_wrap), 64'd1);

        // Randomized traffic with phases of sparse and dense draining.
        for (int ph = 0; ph < 12; ph++) begin
            for (int k = 0; k < 200; k++) begin
                en = ($urandom_range(0, 15) != 0);
                cyc($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom,
                    (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 149) == 0));
            end
        end
        en = 1'b1;
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable commit-trace capture buffer that sits beside the CPU core and records retired instructions (PC, optional register writeback, timestamp) into a parametrised circular buffer. It replaces per-cycle simulation printouts of PC and registers r2..r6 with a hardware-readable stream. Selectable filtering and full-buffer policy let the same block serve as a free-running "last N commits" recorder or as a lossless, stalling-free logger with drop accounting.

## Interface
- PC_W, 32: commit PC width
- DATA_W, 32: writeback data width
- REG_AW, 5: register address width
- DEPTH, 16: entries; power of two, >= 2
- TS_W, 16: timestamp counter width
- WATCH_MASK, 32'h0000_007C: one bit per register; default watches r2..r6
- FILTER, 0: 0 = capture every commit; 1 = capture only commits writing a watched register
- OVERWRITE, 0: 0 = drop new entries when full; 1 = discard oldest when full

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  capture enable
- clear  input  1  synchronous flush
- commit_valid  input  1  one instruction retires this cycle
- commit_pc  input  PC_W  PC of retiring instruction
- wb_en  input  1  retiring instruction writes a register
- wb_addr  input  REG_AW  destination register
- wb_data  input  DATA_W  value written
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_pc  output  PC_W  head PC
- out_has_wb  output  1  head entry carries a writeback
- out_addr  output  REG_AW  head writeback address (0 when out_has_wb = 0)
- out_data  output  DATA_W  head writeback data (0 when out_has_wb = 0)
- out_ts  output  TS_W  head timestamp
- count  output  clog2(DEPTH)+1  occupied entries
- overflow  output  1  sticky: an entry was dropped or overwritten
- dropped  output  16  number of lost entries, saturating at 16'hFFFF

## Operation
- Timestamp counter ts increments every cycle while rst is high; wraps 2^TS_W-1 -> 0; not affected by en or clear.
- hit = wb_en && WATCH_MASK[wb_addr] (bits above 31 never hit; register 0 hits only if mask bit 0 is set).
- push = en && commit_valid && (FILTER == 0 || hit). Entry = {commit_pc, wb_en, wb_en ? wb_addr : 0, wb_en ? wb_data : 0, ts}.
- pop = out_valid && out_ready.
- Storage: circular memory, write pointer and read pointer of clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count tracks occupancy 0..DEPTH.
- Not full: push writes at wptr, wptr+1, count+1 (net of pop).
- Full, pop and push same cycle: both occur, count stays DEPTH, no loss.
- Full, push, no pop, OVERWRITE = 0: entry discarded; overflow <= 1; dropped increments (saturating).
- Full, push, no pop, OVERWRITE = 1: oldest entry discarded (rptr+1), new entry written; count stays DEPTH; overflow <= 1; dropped increments. Head changes without handshake; consumers sample only on pop.
- Empty, push and out_ready: no pop (out_valid low); no bypass.
- clear: rptr, wptr, count, overflow, dropped <= 0; overrides push and pop in that cycle.
- Reset (asynchronous, any time, including mid-readout): pointers, count, ts, overflow, dropped <= 0; out_valid = 0; memory contents need not be reset.

## Timing
- out_valid = (count != 0); out_* driven combinationally from memory at rptr.
- Capture latency: commit on edge N appears at out_* with out_valid = 1 after edge N (visible in cycle N+1) when buffer was empty.
- Throughput: one push and one pop per cycle sustained.
- out_ts equals ts value in the cycle of capture; entries captured in consecutive cycles differ by 1 modulo 2^TS_W.
- count, overflow, dropped update on the same edge as the causing push/pop.

## Test plan
- Reset then 5 commits PC=0,4,8,12,16 with FILTER=0, out_ready=0 -> count=5, out_pc=0; then out_ready=1 -> out_pc 0,4,8,12,16 on consecutive cycles, out_ts consecutive, count returns to 0, out_valid low.
- FILTER=1, commits writing r1, r3=7, r7, r6=9 -> exactly 2 entries: {wb_addr=3, data=7}, {wb_addr=6, data=9}; overflow=0.
- DEPTH=4, OVERWRITE=0, 6 commits PC=0..20 step 4, no pop -> count=4, head PC=0, overflow=1, dropped=2; read order 0,4,8,12.
- DEPTH=4, OVERWRITE=1, same stimulus -> count=4, dropped=2, read order 8,12,16,20.
- Full buffer with simultaneous push and pop for 10 cycles -> count stays 4, dropped unchanged, overflow unchanged; then clear -> count=0, overflow=0, dropped=0 next cycle.
- Assert rst low mid-readout with 3 entries queued -> out_valid=0, count=0 immediately (before next edge); TS_W=4 run 20 cycles -> out_ts wraps 15 -> 0.
